// File: rtl/cfg_bus_arbiter.sv
// cfg_bus_arbiter: round-robin arbiter sharing the register-configuration bus
// between master 0 (host interface) and master 1 (power-up/table loader).
// Latency: req sampled at edge N, cfg_* valid in cycle N+1, ack in cycle N+2;
// a transaction occupies the bus for 3 cycles (IDLE -> ACCESS -> DONE).
// Backpressure: a master holds req until its ack; requests are only sampled
// in IDLE, so a master simply waits while the other master's access runs.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   mN_req/we/addr/wdata             master N request and latched access
//   mN_ack/err/rdata                 master N completion pulse, range error,
//                                    read data (all valid with ack)
//   cfg_we/cfg_addr/cfg_data_in      register-bank access
//   cfg_data_out                     combinational read-back for cfg_addr
//   busy                             high while a transaction is in flight
module cfg_bus_arbiter #(
  parameter int MSB              = 15,
  parameter int MSB_REGS_ADDRESS = 7,
  parameter int MAX_ADDR         = 31
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        m0_req,
  input  logic                        m0_we,
  input  logic [MSB_REGS_ADDRESS:0]   m0_addr,
  input  logic [MSB:0]                m0_wdata,
  output logic                        m0_ack,
  output logic                        m0_err,
  output logic [MSB:0]                m0_rdata,
  input  logic                        m1_req,
  input  logic                        m1_we,
  input  logic [MSB_REGS_ADDRESS:0]   m1_addr,
  input  logic [MSB:0]                m1_wdata,
  output logic                        m1_ack,
  output logic                        m1_err,
  output logic [MSB:0]                m1_rdata,
  output logic                        cfg_we,
  output logic [MSB_REGS_ADDRESS:0]   cfg_addr,
  output logic [MSB:0]                cfg_data_in,
  input  logic [MSB:0]                cfg_data_out,
  output logic                        busy
);

  localparam logic [MSB_REGS_ADDRESS:0] MAX_A = MAX_ADDR[MSB_REGS_ADDRESS:0];

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                      state, state_nxt;
  logic                        last_served, last_nxt;
  logic                        sel, sel_nxt;
  // Write/read direction of the granted access; cfg_we alone cannot tell a
  // read from an out-of-range write.
  logic                        txn_we, txn_we_nxt;
  logic                        addr_bad;

  logic                        cfg_we_nxt;
  logic [MSB_REGS_ADDRESS:0]   cfg_addr_nxt;
  logic [MSB:0]                cfg_data_in_nxt;
  logic                        m0_ack_nxt, m1_ack_nxt;
  logic                        m0_err_nxt, m1_err_nxt;
  logic [MSB:0]                m0_rdata_nxt, m1_rdata_nxt;
  logic                        busy_nxt;

  logic                        win;
  logic                        win_we;
  logic [MSB_REGS_ADDRESS:0]   win_addr;
  logic [MSB:0]                win_wdata;

  // cfg_addr holds the granted address for the whole transaction.
  assign addr_bad = (cfg_addr > MAX_A);

  always_comb begin
    state_nxt       = state;
    last_nxt        = last_served;
    sel_nxt         = sel;
    txn_we_nxt      = txn_we;
    cfg_we_nxt      = cfg_we;
    cfg_addr_nxt    = cfg_addr;
    cfg_data_in_nxt = cfg_data_in;
    m0_ack_nxt      = m0_ack;
    m1_ack_nxt      = m1_ack;
    m0_err_nxt      = m0_err;
    m1_err_nxt      = m1_err;
    m0_rdata_nxt    = m0_rdata;
    m1_rdata_nxt    = m1_rdata;
    busy_nxt        = busy;

    // On a tie the master that was not served last wins.
    win       = (m0_req && m1_req) ? ~last_served : m1_req;
    win_we    = win ? m1_we    : m0_we;
    win_addr  = win ? m1_addr  : m0_addr;
    win_wdata = win ? m1_wdata : m0_wdata;

    case (state)
      IDLE: begin
        cfg_we_nxt = 1'b0;
        if (m0_req || m1_req) begin
          sel_nxt         = win;
          last_nxt        = win;
          txn_we_nxt      = win_we;
          cfg_addr_nxt    = win_addr;
          cfg_data_in_nxt = win_wdata;
          cfg_we_nxt      = win_we && (win_addr <= MAX_A);
          busy_nxt        = 1'b1;
          state_nxt       = ACCESS;
        end
      end
      ACCESS: begin
        cfg_we_nxt = 1'b0;
        if (sel) begin
          m1_ack_nxt = 1'b1;
          m1_err_nxt = addr_bad;
          if (!txn_we && !addr_bad) m1_rdata_nxt = cfg_data_out;
        end else begin
          m0_ack_nxt = 1'b1;
          m0_err_nxt = addr_bad;
          if (!txn_we && !addr_bad) m0_rdata_nxt = cfg_data_out;
        end
        state_nxt = DONE;
      end
      DONE: begin
        m0_ack_nxt = 1'b0;
        m1_ack_nxt = 1'b0;
        m0_err_nxt = 1'b0;
        m1_err_nxt = 1'b0;
        busy_nxt   = 1'b0;
        state_nxt  = IDLE;
      end
      default: begin
        cfg_we_nxt = 1'b0;
        busy_nxt   = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
      sel         <= 1'b0;
      txn_we      <= 1'b0;
      cfg_we      <= 1'b0;
      cfg_addr    <= '0;
      cfg_data_in <= '0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_err      <= 1'b0;
      m1_err      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_served <= last_nxt;
      sel         <= sel_nxt;
      txn_we      <= txn_we_nxt;
      cfg_we      <= cfg_we_nxt;
      cfg_addr    <= cfg_addr_nxt;
      cfg_data_in <= cfg_data_in_nxt;
      m0_ack      <= m0_ack_nxt;
      m1_ack      <= m1_ack_nxt;
      m0_err      <= m0_err_nxt;
      m1_err      <= m1_err_nxt;
      m0_rdata    <= m0_rdata_nxt;
      m1_rdata    <= m1_rdata_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule
